mul_issue_ctrl: RTL and testbench
=================================

// Module: mul_issue_ctrl
// PURPOSE
//   Sequencer for the combinational integer_multiplier (RV64 M-extension MUL/MULH/MULHSU/MULHU).
//   - Accepts one request at a time over valid/ready and drives the multiplier's operands and
//     mode, holding them stable for a LATENCY-cycle multicycle path.
//   - Captures h/l and returns the selected half with the request tag.
//   - Keeps a one-entry result cache so that a MULH* followed by MUL on the same operands
//     (the fused sequence) completes without using the multiplier.
// PARAMETERS
//   LATENCY  2  cycles the multiplier inputs are held before h/l are sampled (>=1)
//   TAG_W    4  width of the request/response tag
// PORTS
//   clk         in   1       clock
//   rst         in   1       asynchronous active-high reset
//   req_valid   in   1       request present
//   req_ready   out  1       request accepted when req_valid & req_ready
//   req_op      in   2       00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_a       in   64      rs1 operand
//   req_b       in   64      rs2 operand
//   req_tag     in   TAG_W   returned unchanged with the response
//   flush       in   1       kill any in-flight or pending operation
//   mul_mode    out  2       to multiplier: bit0 = a signed, bit1 = b signed
//   mul_a       out  64      to multiplier a
//   mul_b       out  64      to multiplier b
//   mul_h       in   64      multiplier high product
//   mul_l       in   64      multiplier low product
//   resp_valid  out  1       response present
//   resp_ready  in   1       response consumed when resp_valid & resp_ready
//   resp_data   out  64      selected product half
//   resp_tag    out  TAG_W   tag of the response
//   busy        out  1       state != IDLE
// BEHAVIOUR
//   Reset: all outputs and state registers are 0. State=IDLE, cache_v=0, req_ready=1 after reset.
//   Op map:
//     MUL    -> mode 11, select l
//     MULH   -> mode 11, select h
//     MULHSU -> mode 01, select h
//     MULHU  -> mode 00, select h
//   States:
//     IDLE -> CALC on a cache miss, IDLE -> RESP on a cache hit.
//     CALC counts cnt down from LATENCY-1; when cnt==0: sample mul_h/mul_l into resp_data and the
//       cache, then go to RESP.
//     RESP holds resp_valid=1 and resp_data/resp_tag stable until resp_ready.
//   req_ready = !flush & (state==IDLE | (state==RESP & resp_ready)).
//     This allows back-to-back operation: a new request is accepted in the same cycle the
//     response is consumed.
//   Accept in cycle T, cache miss:
//     mul_a/mul_b/mul_mode are registered at the end of T and held through CALC.
//     h/l are sampled at the end of T+LATENCY.
//     resp_valid is asserted in T+LATENCY+1.
//   Accept in cycle T, cache hit: resp_valid in T+1; mul_* outputs are unchanged.
//   Cache:
//     Entry fields: {cache_v, ca, cb, cmode, ch, cl}. Written only when a CALC completes.
//     Hit = cache_v & req_a==ca & req_b==cb & (req_op==MUL | map(req_op)==cmode).
//     The low product is sign-independent, so a MUL hits under any cached mode.
//   flush: synchronous, highest priority.
//     - State goes to IDLE next cycle and resp_valid drops.
//     - A CALC in progress is discarded and the cache is not written.
//     - The cache content stays valid.
//     - No request is accepted in a flush cycle.
//   Reset mid-operation: returns immediately to the reset values; the in-flight result is lost.
//   RESP with resp_ready=0: resp_data, resp_tag and resp_valid hold; req_ready=0.
// TESTING
//   - MULH a=-1, b=-1 -> resp_data=0x0; then MUL on the same operands is a cache hit
//     -> resp_data=0x1 one cycle after accept, mul_a/mul_b unchanged.
//   - MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> resp_data=0xFFFF_FFFF_FFFF_FFFE, resp_valid at
//     T+LATENCY+1, mul_mode=00.
//   - MULHSU a=-1, b=2 -> resp_data=0xFFFF_FFFF_FFFF_FFFF with mul_mode=01; then MULHU on the
//     same operands -> cache miss, full latency.
//   - Hold resp_ready=0 for 5 cycles -> resp_valid/resp_data/resp_tag stable and req_ready=0;
//     raise resp_ready together with a new req_valid -> both handshakes occur in the same cycle.
//   - flush in the second cycle of CALC -> resp_valid is never asserted for that tag, busy=0
//     next cycle, and the cache still hits on the previously completed operands.
//   - Assert rst during RESP -> resp_valid=0, busy=0, req_ready=1 after release; the next MUL
//     is a cache miss.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mul_issue_ctrl
//  Purpose  : Request sequencer for a combinational 64x64 integer multiplier
//             (MUL/MULH/MULHSU/MULHU). It holds the operands across a
//             multicycle path, returns the selected product half with the
//             request tag, and caches the most recent full product so that a
//             MULH* followed by a MUL on the same operands skips the
//             multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module mul_issue_ctrl #(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic [1:0]       mul_mode,
  output logic [63:0]      mul_a,
  output logic [63:0]      mul_b,
  input  logic [63:0]      mul_h,
  input  logic [63:0]      mul_l,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam logic [1:0] C_OP_MUL    = 2'b00;
  localparam logic [1:0] C_OP_MULH   = 2'b01;
  localparam logic [1:0] C_OP_MULHSU = 2'b10;
  localparam int         C_CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Signedness selection for each opcode: bit0 = a signed, bit1 = b signed.
  function automatic logic [1:0] op_mode(input logic [1:0] op);
    case (op)
      C_OP_MUL:    op_mode = 2'b11;
      C_OP_MULH:   op_mode = 2'b11;
      C_OP_MULHSU: op_mode = 2'b01;
      default:     op_mode = 2'b00;
    endcase
  endfunction

  state_t             r_state;
  logic [C_CNT_W-1:0] r_cnt;
  logic [63:0]        r_mul_a;
  logic [63:0]        r_mul_b;
  logic [1:0]         r_mul_mode;
  logic               r_sel_l;
  logic               r_resp_valid;
  logic [63:0]        r_resp_data;
  logic [TAG_W-1:0]   r_resp_tag;
  logic               r_cache_v;
  logic [63:0]        r_ca;
  logic [63:0]        r_cb;
  logic [1:0]         r_cmode;
  logic [63:0]        r_ch;
  logic [63:0]        r_cl;

  logic [1:0]         w_req_mode;
  logic               w_req_is_mul;
  logic               w_hit;
  logic               w_req_ready;
  logic               w_accept;

  // Request decode, cache lookup and accept handshake.
  // A MUL only needs the low product, which is the same under every
  // signedness, so it hits regardless of the cached mode.
  always_comb begin
    w_req_mode   = op_mode(req_op);
    w_req_is_mul = (req_op == C_OP_MUL);
    w_hit        = r_cache_v && (req_a == r_ca) && (req_b == r_cb) &&
                   (w_req_is_mul || (w_req_mode == r_cmode));
    w_req_ready  = !flush && ((r_state == S_IDLE) ||
                              ((r_state == S_RESP) && resp_ready));
    w_accept     = req_valid && w_req_ready;
  end

  // Sequencer: accept, multicycle wait, response hold; flush overrides all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_mul_mode   <= '0;
      r_sel_l      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
      r_cache_v    <= 1'b0;
      r_ca         <= '0;
      r_cb         <= '0;
      r_cmode      <= '0;
      r_ch         <= '0;
      r_cl         <= '0;
    end else if (flush) begin
      // Drop whatever is in flight; the cache keeps its last completed entry.
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
    end else if (w_accept) begin
      r_resp_tag <= req_tag;
      r_sel_l    <= w_req_is_mul;
      if (w_hit) begin
        r_resp_data  <= w_req_is_mul ? r_cl : r_ch;
        r_resp_valid <= 1'b1;
        r_state      <= S_RESP;
      end else begin
        r_mul_a      <= req_a;
        r_mul_b      <= req_b;
        r_mul_mode   <= w_req_mode;
        r_cnt        <= C_CNT_W'(LATENCY - 1);
        r_resp_valid <= 1'b0;
        r_state      <= S_CALC;
      end
    end else begin
      case (r_state)
        S_CALC: begin
          if (r_cnt == '0) begin
            r_resp_data  <= r_sel_l ? mul_l : mul_h;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
            r_cache_v    <= 1'b1;
            r_ca         <= r_mul_a;
            r_cb         <= r_mul_b;
            r_cmode      <= r_mul_mode;
            r_ch         <= mul_h;
            r_cl         <= mul_l;
          end else begin
            r_cnt <= r_cnt - C_CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = w_req_ready;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign mul_mode   = r_mul_mode;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_tag   = r_resp_tag;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_issue_ctrl
//  Purpose  : Self-checking bench for mul_issue_ctrl with a behavioural
//             multiplier and a product/cache/latency reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_issue_ctrl;

  localparam int LATENCY = 2;
  localparam int TAG_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [63:0]      req_a = '0;
  logic [63:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             flush = 1'b0;
  logic [1:0]       mul_mode;
  logic [63:0]      mul_a;
  logic [63:0]      mul_b;
  logic [63:0]      mul_h;
  logic [63:0]      mul_l;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [63:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // Reference cache state: last completed computation.
  logic        m_cv = 1'b0;
  logic [63:0] m_ca, m_cb;
  logic [1:0]  m_cmode;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
    .mul_mode(mul_mode), .mul_a(mul_a), .mul_b(mul_b),
    .mul_h(mul_h), .mul_l(mul_l),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy)
  );

  // Behavioural combinational multiplier.
  logic [127:0] w_ea, w_eb, w_prod;
  assign w_ea   = mul_mode[0] ? {{64{mul_a[63]}}, mul_a} : {64'b0, mul_a};
  assign w_eb   = mul_mode[1] ? {{64{mul_b[63]}}, mul_b} : {64'b0, mul_b};
  assign w_prod = w_ea * w_eb;
  assign mul_h  = w_prod[127:64];
  assign mul_l  = w_prod[63:0];

  function automatic logic [1:0] mode_of(input logic [1:0] op);
    case (op)
      2'b10:   mode_of = 2'b01;
      2'b11:   mode_of = 2'b00;
      default: mode_of = 2'b11;
    endcase
  endfunction

  // Architectural result of an RV64M multiply op.
  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] sa, sb, p;
    sa = (op == 2'b11) ? $signed({66'b0, a}) : $signed({{66{a[63]}}, a});
    sb = (op == 2'b00 || op == 2'b01) ? $signed({{66{b[63]}}, b}) : $signed({66'b0, b});
    p  = sa * sb;
    return (op == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  // Predict result and accept-to-valid latency; record completed computations.
  task automatic model_step(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                            output logic [63:0] d, output int lat);
    logic hit;
    hit = m_cv && (a == m_ca) && (b == m_cb) && (op == 2'b00 || mode_of(op) == m_cmode);
    d   = ref_mul(op, a, b);
    lat = hit ? 1 : LATENCY + 1;
    if (!hit) begin
      m_cv = 1'b1; m_ca = a; m_cb = b; m_cmode = mode_of(op);
    end
  endtask

  // Drive one request, measure cycles from accept to resp_valid, then consume it.
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [TAG_W-1:0] tag,
                       output int lat, output logic [63:0] d, output logic [TAG_W-1:0] t);
    int n;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    d = resp_data; t = resp_tag;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_cv = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({mul_a, mul_b, mul_mode} !== '0) begin errors++; $display("FAIL reset_mul_outputs got a=%h b=%h m=%b exp=0", mul_a, mul_b, mul_mode); end
    checks++; if ({resp_data, resp_tag} !== '0) begin errors++; $display("FAIL reset_resp got data=%h tag=%h exp=0", resp_data, resp_tag); end
  endtask

  task automatic test_directed();
    int lat, elat; logic [63:0] d, ed; logic [TAG_W-1:0] t;
    logic [63:0] ones;
    ones = '1;
    // MULH -1*-1 then fused MUL hit
    model_step(2'b01, ones, ones, ed, elat);
    issue(2'b01, ones, ones, 4'h1, lat, d, t);
    checks++; if (d !== 64'h0) begin errors++; $display("FAIL mulh_m1_data got=%h exp=0", d); end
    checks++; if (lat !== LATENCY + 1) begin errors++; $display("FAIL mulh_latency got=%0d exp=%0d", lat, LATENCY + 1); end
    checks++; if (t !== 4'h1) begin errors++; $display("FAIL mulh_tag got=%h exp=1", t); end
    model_step(2'b00, ones, ones, ed, elat);
    issue(2'b00, ones, ones, 4'h2, lat, d, t);
    checks++; if (d !== 64'h1) begin errors++; $display("FAIL mul_hit_data got=%h exp=1", d); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL mul_hit_latency got=%0d exp=1", lat); end
    // MULHU all-ones
    model_step(2'b11, ones, ones, ed, elat);
    issue(2'b11, ones, ones, 4'h3, lat, d, t);
    checks++; if (d !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mulhu_data got=%h exp=fffffffffffffffe", d); end
    checks++; if (lat !== LATENCY + 1) begin errors++; $display("FAIL mulhu_latency got=%0d exp=%0d", lat, LATENCY + 1); end
    checks++; if (mul_mode !== 2'b00) begin errors++; $display("FAIL mulhu_mode got=%b exp=00", mul_mode); end
    // MULHSU -1 * 2, then MULHU same operands misses
    model_step(2'b10, ones, 64'd2, ed, elat);
    issue(2'b10, ones, 64'd2, 4'h4, lat, d, t);
    checks++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mulhsu_data got=%h exp=ffffffffffffffff", d); end
    checks++; if (mul_mode !== 2'b01) begin errors++; $display("FAIL mulhsu_mode got=%b exp=01", mul_mode); end
    model_step(2'b11, ones, 64'd2, ed, elat);
    issue(2'b11, ones, 64'd2, 4'h5, lat, d, t);
    checks++; if (d !== 64'h1) begin errors++; $display("FAIL mulhu_after_hsu_data got=%h exp=1", d); end
    checks++; if (lat !== LATENCY + 1) begin errors++; $display("FAIL mulhu_after_hsu_latency got=%0d exp=%0d", lat, LATENCY + 1); end
  endtask

  task automatic test_random();
    logic [63:0] pool [4];
    int lat, elat; logic [63:0] d, ed, a, b; logic [TAG_W-1:0] t, tag; logic [1:0] op;
    int ia, ib;
    pool[0] = '1; pool[1] = 64'd2; pool[2] = 64'h8000_0000_0000_0000;
    pool[3] = {$urandom, $urandom};
    for (int i = 0; i < 30; i++) begin
      ia = $urandom_range(0, 4); ib = $urandom_range(0, 4);
      a  = (ia == 4) ? {$urandom, $urandom} : pool[ia];
      b  = (ib == 4) ? {$urandom, $urandom} : pool[ib];
      op = 2'($urandom_range(0, 3));
      tag = TAG_W'($urandom);
      model_step(op, a, b, ed, elat);
      issue(op, a, b, tag, lat, d, t);
      checks++; if (d !== ed) begin errors++; $display("FAIL rand_data[%0d] op=%0d got=%h exp=%h", i, op, d, ed); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, elat); end
      checks++; if (t !== tag) begin errors++; $display("FAIL rand_tag[%0d] got=%h exp=%h", i, t, tag); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, elat, n; logic [63:0] d0, ed, ed2; logic [TAG_W-1:0] t0;
    logic stable, blocked, both;
    model_step(2'b01, 64'd12345, 64'hFFFF_FFFF_FFFF_FF00, ed, elat);
    req_valid = 1'b1; req_op = 2'b01; req_a = 64'd12345; req_b = 64'hFFFF_FFFF_FFFF_FF00; req_tag = 4'h9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    d0 = resp_data; t0 = resp_tag;
    checks++; if (d0 !== ed) begin errors++; $display("FAIL bp_data got=%h exp=%h", d0, ed); end
    stable = 1'b1; blocked = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_data !== ed || resp_tag !== 4'h9) stable = 1'b0;
      if (req_ready !== 1'b0) blocked = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL bp_hold got valid=%b data=%h tag=%h exp=1/%h/9", resp_valid, resp_data, resp_tag, ed); end
    checks++; if (!blocked) begin errors++; $display("FAIL bp_req_ready got=%b exp=0", req_ready); end
    // New request and response consume in the same cycle
    model_step(2'b10, 64'h7, 64'hFFFF_FFFF_FFFF_FFF0, ed2, elat);
    resp_ready = 1'b1; req_valid = 1'b1; req_op = 2'b10; req_a = 64'h7;
    req_b = 64'hFFFF_FFFF_FFFF_FFF0; req_tag = 4'hA;
    @(negedge clk);
    both = resp_valid && req_ready;
    checks++; if (!both) begin errors++; $display("FAIL b2b_handshake got valid=%b ready=%b exp=1/1", resp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (resp_data !== ed2 || resp_tag !== 4'hA) begin errors++; $display("FAIL b2b_resp got data=%h tag=%h exp=%h/a", resp_data, resp_tag, ed2); end
    checks++; if (lat !== elat) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, elat); end
    resp_ready = 1'b1; @(posedge clk); #1; resp_ready = 1'b0;
  endtask

  task automatic test_flush();
    int lat, elat; logic [63:0] d, ed, xa, xb, ya, yb; logic [TAG_W-1:0] t;
    logic leaked;
    xa = 64'h1234; xb = 64'hFFFF_FFFF_FFFF_FFF9; ya = 64'hDEAD_BEEF; yb = 64'h55;
    model_step(2'b01, xa, xb, ed, elat);
    issue(2'b01, xa, xb, 4'h6, lat, d, t);
    checks++; if (d !== ed) begin errors++; $display("FAIL flush_pre_data got=%h exp=%h", d, ed); end
    // Miss on Y, flushed in its second CALC cycle
    req_valid = 1'b1; req_op = 2'b11; req_a = ya; req_b = yb; req_tag = 4'hC;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    req_valid = 1'b1; req_op = 2'b00; req_a = xa; req_b = xb; req_tag = 4'hD;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_req_ready got=%b exp=0", req_ready); end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL flush_idle got busy=%b valid=%b exp=0/0", busy, resp_valid); end
    leaked = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (resp_valid !== 1'b0) leaked = 1'b1; end
    checks++; if (leaked) begin errors++; $display("FAIL flush_leak got resp_valid=1 exp=0"); end
    // Cache still holds X; multiplier inputs still hold Y
    model_step(2'b00, xa, xb, ed, elat);
    issue(2'b00, xa, xb, 4'hE, lat, d, t);
    checks++; if (d !== ed || lat !== 1) begin errors++; $display("FAIL flush_cache_hit got data=%h lat=%0d exp=%h/1", d, lat, ed); end
    checks++; if (mul_a !== ya || mul_b !== yb) begin errors++; $display("FAIL hit_mul_unchanged got a=%h b=%h exp=%h/%h", mul_a, mul_b, ya, yb); end
    model_step(2'b11, ya, yb, ed, elat);
    issue(2'b11, ya, yb, 4'hF, lat, d, t);
    checks++; if (d !== ed || lat !== elat) begin errors++; $display("FAIL flush_retry got data=%h lat=%0d exp=%h/%0d", d, lat, ed, elat); end
  endtask

  task automatic test_reset_mid();
    int lat, elat, n; logic [63:0] d, ed; logic [TAG_W-1:0] t;
    model_step(2'b00, 64'd3, 64'd5, ed, elat);
    req_valid = 1'b1; req_op = 2'b00; req_a = 64'd3; req_b = 64'd5; req_tag = 4'h7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    #2 rst = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid got valid=%b busy=%b exp=0/0", resp_valid, busy); end
    @(posedge clk); #1 rst = 1'b0;
    m_cv = 1'b0;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_release got ready=%b busy=%b exp=1/0", req_ready, busy); end
    model_step(2'b00, 64'd3, 64'd5, ed, elat);
    issue(2'b00, 64'd3, 64'd5, 4'h8, lat, d, t);
    checks++; if (d !== 64'd15 || lat !== LATENCY + 1) begin errors++; $display("FAIL rst_cache_miss got data=%h lat=%0d exp=f/%0d", d, lat, LATENCY + 1); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
